uart_tx_ctrl: RTL and testbench

//  Memory-mapped UART transmit controller for the krv32 SoC IO space. Replaces the raw

---
 rtl/uart_tx_ctrl_pkg.sv | 22 ++
 rtl/uart_tx_ctrl_sync_fifo.sv | 52 +++++
 rtl/uart_tx_ctrl.sv | 147 ++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART transmit controller: register offsets,
// STATUS bit positions and the transmit FSM state type.
package uart_tx_ctrl_pkg;

    localparam logic [1:0] UART_DATA    = 2'd0;
    localparam logic [1:0] UART_STATUS  = 2'd1;
    localparam logic [1:0] UART_DIVISOR = 2'd2;

    localparam int ST_ACTIVE    = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_ctrl_sync_fifo.sv
// Single-clock FIFO holding bytes queued by the CPU until the transmitter
// takes them. A push into a full FIFO succeeds only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped UART transmitter: CPU bytes are queued in a FIFO and sent
// as 8N1 frames at a programmable number of clock cycles per bit.
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16,
    parameter int DIV_RESET  = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic             wr_data;
    logic             wr_status;
    logic             wr_div;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;
    logic [CW-1:0]    fifo_count;
    logic             overflow;
    logic [DIV_W-1:0] divisor;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shifter;
    logic             bit_done;
    logic [31:0]      status;
    tx_state_t        state;

    assign wr_data   = sel & we & (addr == UART_DATA);
    assign wr_status = sel & we & (addr == UART_STATUS);
    assign wr_div    = sel & we & (addr == UART_DIVISOR);
    assign bit_done  = (bit_cnt == '0);
    assign fifo_pop  = ~fifo_empty & ((state == IDLE) | ((state == STOP) & bit_done));
    assign busy      = (state != IDLE) | ~fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_data),
        .pop   (fifo_pop),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            divisor  <= DIV_W'(DIV_RESET);
        end else begin
            if (wr_data & fifo_full & ~fifo_pop)
                overflow <= 1'b1;
            else if (wr_status & wdata[ST_OVERFLOW])
                overflow <= 1'b0;
            if (wr_div)
                divisor <= (wdata[DIV_W-1:0] == '0) ? DIV_W'(1) : wdata[DIV_W-1:0];
        end
    end

    always_comb begin
        status                        = '0;
        status[ST_ACTIVE]             = (state != IDLE);
        status[ST_FULL]               = fifo_full;
        status[ST_EMPTY]              = fifo_empty;
        status[ST_OVERFLOW]           = overflow;
        status[ST_COUNT_LSB +: CW]    = fifo_count;
        rdata = '0;
        if (sel & ~we) begin
            case (addr)
                UART_STATUS:  rdata = status;
                UART_DIVISOR: rdata = 32'(divisor);
                default:      rdata = '0;
            endcase
        end
    end

    // tx follows the state one cycle late, so a frame starting in state START
    // appears on the line the cycle after the pop; a pop from IDLE or at the
    // end of STOP loads the next byte without an idle gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            div_q   <= DIV_W'(DIV_RESET);
            bit_cnt <= '0;
            bit_idx <= '0;
            shifter <= '0;
        end else begin
            case (state)
                START:   tx <= 1'b0;
                DATA:    tx <= shifter[0];
                default: tx <= 1'b1;
            endcase
            if (fifo_pop) begin
                shifter <= fifo_dout;
                div_q   <= divisor;
                bit_cnt <= divisor - 1'b1;
                state   <= START;
            end else begin
                case (state)
                    START: begin
                        if (bit_done) begin
                            bit_cnt <= div_q - 1'b1;
                            bit_idx <= '0;
                            state   <= DATA;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                    DATA: begin
                        if (bit_done) begin
                            bit_cnt <= div_q - 1'b1;
                            shifter <= shifter >> 1;
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == 3'd7) state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                    STOP: begin
                        if (bit_done) state   <= IDLE;
                        else          bit_cnt <= bit_cnt - 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a frame-level reference model predicts
// tx, busy and read data every cycle, backed by hand-computed literal checks.
module tb_uart_tx_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        tx;
    logic        busy;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    logic [7:0]  exp_q[$];
    bit          wave[$];
    logic [15:0] div_m = 16'd868;
    bit          ovf_m = 1'b0;
    bit          exp_tx = 1'b1;
    logic [7:0]  mb;
    int          md;
    logic [7:0]  pat;

    uart_tx_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each popped byte becomes a queue of 10*divisor line
    // levels; the transmitter is free exactly when that queue has drained.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            wave.delete();
            div_m  = 16'd868;
            ovf_m  = 1'b0;
            exp_tx = 1'b1;
        end else begin
            exp_tx = (wave.size() != 0) ? wave.pop_front() : 1'b1;
            if (wave.size() == 0 && exp_q.size() != 0) begin
                mb = exp_q.pop_front();
                md = int'(div_m);
                for (int i = 0; i < 10; i++)
                    for (int j = 0; j < md; j++)
                        wave.push_back(i == 0 ? 1'b0 : (i == 9 ? 1'b1 : mb[i-1]));
            end
            if (sel && we) begin
                if (addr == 2'd0) begin
                    if (exp_q.size() < 8) exp_q.push_back(wdata[7:0]);
                    else                  ovf_m = 1'b1;
                end else if (addr == 2'd1 && wdata[3]) begin
                    ovf_m = 1'b0;
                end else if (addr == 2'd2) begin
                    div_m = (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
                end
            end
        end
    end

    function automatic logic [31:0] expRdata();
        logic [31:0] r = '0;
        int n = exp_q.size();
        if (sel && !we) begin
            if (addr == 2'd1) begin
                r[0]   = (wave.size() != 0);
                r[1]   = (n == 8);
                r[2]   = (n == 0);
                r[3]   = ovf_m;
                r[7:4] = 4'(n);
            end else if (addr == 2'd2) begin
                r = 32'(div_m);
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("tx_model", {31'd0, tx}, {31'd0, exp_tx});
            checkOutput("busy_model", {31'd0, busy}, {31'd0, (wave.size() != 0 || exp_q.size() != 0)});
            checkOutput("rdata_model", rdata, expRdata());
        end
    end

    task automatic applyStimulus(input logic s, input logic w, input logic [1:0] a, input logic [31:0] d);
        sel = s; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = '0;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic readCheck(input logic [1:0] a, input logic [31:0] exp, input string name);
        sel = 1'b1; we = 1'b0; addr = a; wdata = '0;
        #2;
        checkOutput(name, rdata, exp);
        @(posedge clk); #1;
        sel = 1'b0; addr = 2'd0;
    endtask

    initial begin
        int r;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        chk_en = 1'b1;
        waitEdges(1);

        checkOutput("reset_tx", {31'd0, tx}, 32'd1);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        readCheck(2'd1, 32'h4, "reset_status");
        readCheck(2'd2, 32'd868, "reset_divisor");
        applyStimulus(1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF);
        readCheck(2'd3, 32'h0, "reserved_read");
        readCheck(2'd0, 32'h0, "data_read");

        // Single 0xA5 frame at 4 cycles per bit.
        applyStimulus(1'b1, 1'b1, 2'd2, 32'd4);
        applyStimulus(1'b1, 1'b1, 2'd0, 32'hA5);
        checkOutput("a5_tx_n", {31'd0, tx}, 32'd1);
        waitEdges(1);
        checkOutput("a5_tx_n1", {31'd0, tx}, 32'd1);
        waitEdges(1);
        checkOutput("a5_start", {31'd0, tx}, 32'd0);
        waitEdges(4);
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("a5_bit%0d", i), {31'd0, tx}, {31'd0, pat[i]});
            waitEdges(4);
        end
        checkOutput("a5_stop", {31'd0, tx}, 32'd1);
        waitEdges(2);
        checkOutput("a5_busy_end", {31'd0, busy}, 32'd1);
        waitEdges(1);
        checkOutput("a5_busy_fall", {31'd0, busy}, 32'd0);

        // Ten back-to-back writes: one popped, eight queued, one dropped.
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 2'd0, 32'(8'h30 + i));
        readCheck(2'd1, 32'h8B, "burst_status");
        applyStimulus(1'b1, 1'b1, 2'd1, 32'h8);
        readCheck(2'd1, 32'h83, "ovf_cleared");
        waitEdges(400);

        // Divisor change during frame 1 only affects frame 2.
        applyStimulus(1'b1, 1'b1, 2'd0, 32'h3C);
        applyStimulus(1'b1, 1'b1, 2'd0, 32'hC3);
        applyStimulus(1'b1, 1'b1, 2'd2, 32'd2);
        waitEdges(58);
        checkOutput("div_busy_end", {31'd0, busy}, 32'd1);
        waitEdges(1);
        checkOutput("div_busy_fall", {31'd0, busy}, 32'd0);

        // Divisor 0 is stored as 1: a 10-cycle frame.
        applyStimulus(1'b1, 1'b1, 2'd2, 32'd0);
        readCheck(2'd2, 32'd1, "div_zero_read");
        applyStimulus(1'b1, 1'b1, 2'd0, 32'h5A);
        waitEdges(10);
        checkOutput("div1_busy_end", {31'd0, busy}, 32'd1);
        waitEdges(1);
        checkOutput("div1_busy_fall", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of the data bits.
        applyStimulus(1'b1, 1'b1, 2'd2, 32'd4);
        applyStimulus(1'b1, 1'b1, 2'd0, 32'h00);
        applyStimulus(1'b1, 1'b1, 2'd0, 32'h11);
        waitEdges(10);
        checkOutput("pre_reset_tx", {31'd0, tx}, 32'd0);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_reset_tx", {31'd0, tx}, 32'd1);
        checkOutput("async_reset_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        waitEdges(30);
        checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);
        readCheck(2'd1, 32'h4, "post_reset_status");
        readCheck(2'd2, 32'd868, "post_reset_divisor");

        // Randomized traffic against the model.
        applyStimulus(1'b1, 1'b1, 2'd2, 32'($urandom_range(1, 3)));
        for (int k = 0; k < 4000; k++) begin
            r = $urandom_range(0, 99);
            if (r < 40)      waitEdges(1);
            else if (r < 70) applyStimulus(1'b1, 1'b1, 2'd0, $urandom);
            else if (r < 85) applyStimulus(1'b1, 1'b0, 2'd1, 32'd0);
            else if (r < 90) applyStimulus(1'b1, 1'b0, 2'd2, 32'd0);
            else if (r < 94) applyStimulus(1'b1, 1'b1, 2'd2, 32'($urandom_range(0, 3)));
            else if (r < 97) applyStimulus(1'b1, 1'b1, 2'd1, $urandom);
            else             applyStimulus(1'b1, $urandom_range(0, 1) == 1, 2'd3, $urandom);
        end
        for (int k = 0; k < 1000 && busy; k++) waitEdges(1);
        checkOutput("drain_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
